mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
- Parametrised mole placement and timing engine for whack-a-mole: N_HOLES holes, configurable mole lifetime, and a blank gap between moles.
- Draws positions from a Galois LFSR using rejection sampling (no modulo bias, no immediate repeat).
- Accepts player hit events and reports hit, wrong-hole and miss outcomes.
- Sits between the input debouncer/decoder and the score and display logic.

Parameters:
N_HOLES, 5, number of holes; legal range 2..16
POS_W, 3, position index width; 2**POS_W >= N_HOLES
LFSR_W, 16, LFSR width; LFSR_W >= POS_W
LFSR_TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1)
LFSR_SEED, 16'hACE1, reset value; 0 is forced to 1
CNT_W, 28, lifetime and gap counter width
GAP_CYCLES, 25000000, blank cycles between moles (>=1)
SPEEDUP_STEP, 5000000, lifetime reduction per hit (feature only)
MIN_LIFETIME, 10000000, lifetime floor (feature only)

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-high reset
i_enable  in  1  run/pause
i_lifetime  in  CNT_W  mole visible time in cycles; sampled at mole spawn
i_hit_valid  in  1  one-cycle hit strobe
i_hit_pos  in  POS_W  hole index of the hit
o_mole_valid  out  1  mole currently shown
o_mole_pos  out  POS_W  current or last mole index
o_mole_onehot  out  N_HOLES  one-hot of shown mole; 0 when none is shown
o_position_changed  out  1  one-cycle pulse on spawn
o_hit_ok  out  1  pulse: correct hit
o_hit_wrong  out  1  pulse: hit on an empty hole while a mole is shown
o_miss  out  1  pulse: lifetime expired without a hit

Behaviour:
- Reset, asynchronous and effective at any time including mid-operation:
  - state = IDLE; all outputs 0; LFSR = LFSR_SEED.
  - last_pos = N_HOLES (invalid marker); lifetime offset = 0.
- LFSR:
  - Shifts right every clock in every state.
  - If lfsr[0] = 1, the shifted value is XORed with LFSR_TAPS.
  - Never reaches 0.
- All outputs are registered. An event sampled at edge t appears at t+1.
- FSM states: IDLE, PICK, SHOW, GAP.
- IDLE:
  - Moves to PICK when i_enable = 1.
- PICK:
  - cand = lfsr[POS_W-1:0].
  - Accept if cand < N_HOLES and cand != last_pos. Otherwise retry on the next cycle.
  - On accept, all of the following happen together:
    - o_mole_pos = cand; o_mole_onehot = 1<<cand.
    - o_mole_valid = 1; o_position_changed = 1 for one cycle.
    - last_pos = cand.
    - Counter loaded with the effective lifetime; 0 is treated as 1.
    - Next state = SHOW.
- SHOW: o_mole_valid stays high for exactly lifetime enabled cycles.
  - Correct hit (i_hit_valid and i_hit_pos == o_mole_pos): o_hit_ok pulses; o_mole_valid and o_mole_onehot clear; go to GAP.
  - Wrong hit: o_hit_wrong pulses; mole stays; counter continues.
  - Expiry (counter == 1 and decrementing): o_miss pulses; mole clears; go to GAP.
  - Correct hit in the same cycle as expiry: hit wins; o_miss is not asserted.
  - i_hit_pos >= N_HOLES counts as a wrong hit.
- GAP:
  - Counter loaded with GAP_CYCLES on entry. When the count elapses, go to PICK.
  - Hits in GAP are ignored; no pulses.
- Pause (i_enable = 0):
  - SHOW, GAP and PICK hold state and counter; the LFSR still runs.
  - The mole stays displayed; hits are ignored.
  - In IDLE, the FSM stays in IDLE.
- No other event leaves IDLE once the FSM is running. Only reset returns to IDLE.

Optional Feature:
MOLE_SPEEDUP_EN
- Defined:
  - Each o_hit_ok adds SPEEDUP_STEP to an internal offset, saturating at CNT_W max.
  - Effective lifetime = max(i_lifetime - offset, MIN_LIFETIME), with no underflow.
  - If i_lifetime < MIN_LIFETIME, i_lifetime is used unchanged.
  - The offset clears only on reset.
- Undefined: effective lifetime = i_lifetime exactly; no offset register is built.

Test Plan (N_HOLES=5, GAP_CYCLES=4, i_lifetime=10, feature off unless stated):
- Reset, then i_enable=1: o_position_changed pulses within 64 cycles; o_mole_pos < 5; onehot matches; all outputs were 0 during reset.
- No hits: o_mole_valid high exactly 10 cycles; o_miss pulses once at the cycle valid falls; valid low 4 cycles; the next spawn follows PICK.
- Correct hit on the 3rd SHOW cycle: o_hit_ok pulses once the next cycle; valid drops the same cycle; no o_miss; respawn follows the 4-cycle GAP plus PICK.
- Wrong hit, then correct hit in the expiry cycle: o_hit_wrong pulses; mole kept; at expiry o_hit_ok=1 and o_miss=0.
- Pause and reset:
  - i_enable=0 for 7 cycles mid-SHOW: valid held and expiry delayed by exactly 7 cycles.
  - Asserting i_rst mid-SHOW: outputs 0 immediately, before the next clock edge.
- 2000 spawns, random hits:
  - Positions are always < 5, never equal consecutively, and every hole is used at least 200 times.
  - With MOLE_SPEEDUP_EN, MIN_LIFETIME=4, SPEEDUP_STEP=2: lifetimes after 0, 1, 2, 3 hits are 10, 8, 6, 4, then stay at 4.

Source files
------------

// File: rtl/mole_scheduler.sv
// ---------------------------------------------------------------------------
// mole_scheduler
//
// Purpose:
//   Mole placement and timing engine for whack-a-mole. A free-running Galois
//   LFSR supplies candidate hole indices. Candidates that are out of range or
//   equal to the previous mole are rejected, so there is no modulo bias and
//   no immediate repeat. The engine shows each mole for a lifetime, reports
//   player hits, wrong-hole hits and misses, and then leaves a blank gap
//   before the next mole.
//
// Optional feature (compile-time macro MOLE_SPEEDUP_EN):
//   Each correct hit shortens later lifetimes by SPEEDUP_STEP, down to a
//   floor of MIN_LIFETIME. With the macro undefined, the lifetime is
//   i_lifetime exactly and no offset register is built.
//
// Ports:
//   i_clk              system clock
//   i_rst              asynchronous active-high reset
//   i_enable           run (1) / pause (0)
//   i_lifetime         mole visible time in cycles, sampled at spawn
//   i_hit_valid        one-cycle hit strobe
//   i_hit_pos          hole index of the hit
//   o_mole_valid       a mole is currently shown
//   o_mole_pos         index of the current or last mole
//   o_mole_onehot      one-hot of the shown mole, 0 when none is shown
//   o_position_changed one-cycle pulse when a mole spawns
//   o_hit_ok           pulse: correct hit
//   o_hit_wrong        pulse: hit on an empty hole while a mole is shown
//   o_miss             pulse: lifetime expired without a hit
// ---------------------------------------------------------------------------
module mole_scheduler #(
    parameter int                N_HOLES      = 5,
    parameter int                POS_W        = 3,
    parameter int                LFSR_W       = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 16'hACE1,
    parameter int                CNT_W        = 28,
    parameter int                GAP_CYCLES   = 25000000,
    parameter int                SPEEDUP_STEP = 5000000,
    parameter int                MIN_LIFETIME = 10000000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic [CNT_W-1:0]   i_lifetime,
    input  logic               i_hit_valid,
    input  logic [POS_W-1:0]   i_hit_pos,
    output logic               o_mole_valid,
    output logic [POS_W-1:0]   o_mole_pos,
    output logic [N_HOLES-1:0] o_mole_onehot,
    output logic               o_position_changed,
    output logic               o_hit_ok,
    output logic               o_hit_wrong,
    output logic               o_miss
);

    if (N_HOLES < 2 || N_HOLES > 16 || (2**POS_W) < N_HOLES || LFSR_W < POS_W ||
        GAP_CYCLES < 1 || SPEEDUP_STEP < 0 || MIN_LIFETIME < 0) begin : g_param_check
        $error("mole_scheduler: illegal parameter combination");
    end

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_SAFE = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES);
    // last_pos is one bit wider than a position so that N_HOLES always fits
    // as the "no previous mole" marker, even when N_HOLES == 2**POS_W.
    localparam logic [POS_W:0]    HOLES_LIM = (POS_W+1)'(N_HOLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PICK = 2'd1,
        SHOW = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [POS_W:0]     last_pos_q, last_pos_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mole_valid_q, mole_valid_d;
    logic [POS_W-1:0]   mole_pos_q, mole_pos_d;
    logic [N_HOLES-1:0] mole_onehot_q, mole_onehot_d;
    logic               pos_changed_q, pos_changed_d;
    logic               hit_ok_q, hit_ok_d;
    logic               hit_wrong_q, hit_wrong_d;
    logic               miss_q, miss_d;

    logic [POS_W-1:0]   cand;
    logic               cand_ok;
    logic [CNT_W-1:0]   eff_lifetime;
    logic [CNT_W-1:0]   life_load;

    // Galois LFSR step: shift right, fold the taps in when a 1 falls out.
    always_comb begin
        lfsr_d = lfsr_q >> 1;
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    // Rejection sampling: only in-range candidates that differ from the
    // previous mole are accepted; anything else waits for the next LFSR value.
    always_comb begin
        cand    = lfsr_q[POS_W-1:0];
        cand_ok = ({1'b0, cand} < HOLES_LIM) && ({1'b0, cand} != last_pos_q);
    end

`ifdef MOLE_SPEEDUP_EN
    localparam logic [CNT_W-1:0] MIN_LIFE = CNT_W'(MIN_LIFETIME);
    localparam logic [CNT_W:0]   STEP_EXT = (CNT_W+1)'(SPEEDUP_STEP);

    logic [CNT_W-1:0] offset_q, offset_d;
    logic [CNT_W:0]   offset_sum;

    // Lifetimes already below the floor pass through untouched; otherwise
    // the offset is subtracted but never takes the result under the floor.
    always_comb begin
        if (i_lifetime < MIN_LIFE) begin
            eff_lifetime = i_lifetime;
        end else if (offset_q > (i_lifetime - MIN_LIFE)) begin
            eff_lifetime = MIN_LIFE;
        end else begin
            eff_lifetime = i_lifetime - offset_q;
        end
    end

    // The offset grows by one step per correct hit and saturates at all-ones.
    always_comb begin
        offset_sum = {1'b0, offset_q} + STEP_EXT;
        offset_d   = offset_q;
        if (hit_ok_d) begin
            offset_d = offset_sum[CNT_W] ? '1 : offset_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end
`else
    always_comb begin
        eff_lifetime = i_lifetime;
    end
`endif

    // A zero lifetime still shows the mole for one cycle.
    always_comb begin
        life_load = (eff_lifetime == '0) ? CNT_W'(1) : eff_lifetime;
    end

    // Next-state and registered-output logic. Pulses default low every cycle;
    // with i_enable low the PICK, SHOW and GAP states freeze completely.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_pos_d    = last_pos_q;
        mole_valid_d  = mole_valid_q;
        mole_pos_d    = mole_pos_q;
        mole_onehot_d = mole_onehot_q;
        pos_changed_d = 1'b0;
        hit_ok_d      = 1'b0;
        hit_wrong_d   = 1'b0;
        miss_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_enable) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                if (i_enable && cand_ok) begin
                    mole_pos_d    = cand;
                    mole_onehot_d = N_HOLES'(1) << cand;
                    mole_valid_d  = 1'b1;
                    pos_changed_d = 1'b1;
                    last_pos_d    = {1'b0, cand};
                    cnt_d         = life_load;
                    state_d       = SHOW;
                end
            end
            SHOW: begin
                if (i_enable) begin
                    // A correct hit takes priority over a simultaneous expiry.
                    if (i_hit_valid && (i_hit_pos == mole_pos_q)) begin
                        hit_ok_d      = 1'b1;
                        mole_valid_d  = 1'b0;
                        mole_onehot_d = '0;
                        cnt_d         = GAP_LOAD;
                        state_d       = GAP;
                    end else begin
                        if (i_hit_valid) begin
                            hit_wrong_d = 1'b1;
                        end
                        if (cnt_q == CNT_W'(1)) begin
                            miss_d        = 1'b1;
                            mole_valid_d  = 1'b0;
                            mole_onehot_d = '0;
                            cnt_d         = GAP_LOAD;
                            state_d       = GAP;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
            end
            GAP: begin
                if (i_enable) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = PICK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, LFSR and output registers; reset clears everything at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= IDLE;
            lfsr_q        <= SEED_SAFE;
            last_pos_q    <= HOLES_LIM;
            cnt_q         <= '0;
            mole_valid_q  <= 1'b0;
            mole_pos_q    <= '0;
            mole_onehot_q <= '0;
            pos_changed_q <= 1'b0;
            hit_ok_q      <= 1'b0;
            hit_wrong_q   <= 1'b0;
            miss_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            lfsr_q        <= lfsr_d;
            last_pos_q    <= last_pos_d;
            cnt_q         <= cnt_d;
            mole_valid_q  <= mole_valid_d;
            mole_pos_q    <= mole_pos_d;
            mole_onehot_q <= mole_onehot_d;
            pos_changed_q <= pos_changed_d;
            hit_ok_q      <= hit_ok_d;
            hit_wrong_q   <= hit_wrong_d;
            miss_q        <= miss_d;
        end
    end

    assign o_mole_valid       = mole_valid_q;
    assign o_mole_pos         = mole_pos_q;
    assign o_mole_onehot      = mole_onehot_q;
    assign o_position_changed = pos_changed_q;
    assign o_hit_ok           = hit_ok_q;
    assign o_hit_wrong        = hit_wrong_q;
    assign o_miss             = miss_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mole_scheduler
//
// Self-checking bench for mole_scheduler (N_HOLES=5, GAP_CYCLES=4,
// lifetime 10). Expected spawn times and positions come from the LFSR rule
// and the rejection rule applied to a bench-side LFSR value; expected
// lifetimes, pulses and gap lengths come from plain per-mole arithmetic.
// Build with MOLE_SPEEDUP_EN defined to exercise the lifetime speedup.
// ---------------------------------------------------------------------------
module tb_mole_scheduler;

    localparam int          N_HOLES      = 5;
    localparam int          POS_W        = 3;
    localparam int          LFSR_W       = 16;
    localparam int          CNT_W        = 8;
    localparam int          GAP_CYCLES   = 4;
    localparam int          SPEEDUP_STEP = 2;
    localparam int          MIN_LIFETIME = 4;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    logic               i_clk       = 1'b0;
    logic               i_rst       = 1'b1;
    logic               i_enable    = 1'b0;
    logic [CNT_W-1:0]   i_lifetime  = 8'd10;
    logic               i_hit_valid = 1'b0;
    logic [POS_W-1:0]   i_hit_pos   = '0;
    logic               o_mole_valid;
    logic [POS_W-1:0]   o_mole_pos;
    logic [N_HOLES-1:0] o_mole_onehot;
    logic               o_position_changed;
    logic               o_hit_ok;
    logic               o_hit_wrong;
    logic               o_miss;

    int          checks   = 0;
    int          errors   = 0;
    int          last_pos = N_HOLES;
    int          prev_obs = -1;
    int          ok_hits  = 0;
    int          hole_count [N_HOLES];
    logic [15:0] m_lfsr   = LFSR_SEED;

    mole_scheduler #(
        .N_HOLES      (N_HOLES),
        .POS_W        (POS_W),
        .LFSR_W       (LFSR_W),
        .LFSR_TAPS    (LFSR_TAPS),
        .LFSR_SEED    (LFSR_SEED),
        .CNT_W        (CNT_W),
        .GAP_CYCLES   (GAP_CYCLES),
        .SPEEDUP_STEP (SPEEDUP_STEP),
        .MIN_LIFETIME (MIN_LIFETIME)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_enable           (i_enable),
        .i_lifetime         (i_lifetime),
        .i_hit_valid        (i_hit_valid),
        .i_hit_pos          (i_hit_pos),
        .o_mole_valid       (o_mole_valid),
        .o_mole_pos         (o_mole_pos),
        .o_mole_onehot      (o_mole_onehot),
        .o_position_changed (o_position_changed),
        .o_hit_ok           (o_hit_ok),
        .o_hit_wrong        (o_hit_wrong),
        .o_miss             (o_miss)
    );

    always #5 i_clk = ~i_clk;

    // One LFSR step straight from the shift-and-fold rule.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ LFSR_TAPS;
        return r;
    endfunction

    // Visible time of the mole that has just spawned.
    function automatic int exp_lifetime();
        int l;
        l = int'(i_lifetime);
`ifdef MOLE_SPEEDUP_EN
        if (l >= MIN_LIFETIME) begin
            l = l - SPEEDUP_STEP * ok_hits;
            if (l < MIN_LIFETIME) l = MIN_LIFETIME;
        end
`endif
        if (l == 0) l = 1;
        return l;
    endfunction

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Every output except the retained position must be low.
    task automatic check_quiet(input string tag);
        check_bit({tag, "_valid"},   o_mole_valid,       1'b0);
        check_val({tag, "_onehot"},  int'(o_mole_onehot), 0);
        check_bit({tag, "_changed"}, o_position_changed, 1'b0);
        check_bit({tag, "_hit_ok"},  o_hit_ok,           1'b0);
        check_bit({tag, "_wrong"},   o_hit_wrong,        1'b0);
        check_bit({tag, "_miss"},    o_miss,             1'b0);
    endtask

    // Advance one running clock; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge i_clk);
        m_lfsr = lfsr_next(m_lfsr);
        #1;
    endtask

    // Wait for the spawn predicted by the rejection rule, checking each cycle.
    task automatic do_pick();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            logic [POS_W-1:0] cand;
            bit               acc;
            cand = m_lfsr[POS_W-1:0];
            acc  = (int'(cand) < N_HOLES) && (int'(cand) != last_pos);
            step();
            check_bit("pick_changed", o_position_changed, acc);
            if (acc) begin
                found = 1'b1;
                check_val("spawn_pos",    int'(o_mole_pos),    int'(cand));
                check_bit("spawn_valid",  o_mole_valid,        1'b1);
                check_val("spawn_onehot", int'(o_mole_onehot), 1 << cand);
                check_bit("spawn_range_norepeat",
                          (int'(o_mole_pos) < N_HOLES) && (int'(o_mole_pos) != prev_obs), 1'b1);
                prev_obs = int'(o_mole_pos);
                last_pos = int'(cand);
                hole_count[cand]++;
            end else begin
                check_bit("pick_valid", o_mole_valid, 1'b0);
            end
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("[TB] FAIL pick_timeout: observed no spawn in 64 cycles, expected a spawn");
        end
    endtask

    // Run one visible mole. hit_at: enabled SHOW cycle of the correct hit
    // (-1 none, 0 the expiry cycle); wrong_at: cycle of a wrong hit (0 none);
    // pause_at/pause_len: a pause inserted before that SHOW cycle.
    task automatic apply_stimulus(input int hit_at, input int wrong_at,
                                  input logic [POS_W-1:0] wrong_pos,
                                  input int pause_at, input int pause_len);
        int L;
        int mole;
        bit done;
        L    = exp_lifetime();
        mole = last_pos;
        done = 1'b0;
        if (hit_at == 0) hit_at = L;
        for (int e = 1; e <= L && !done; e++) begin
            if (e == pause_at) begin
                i_enable    = 1'b0;
                i_hit_valid = 1'b1;
                i_hit_pos   = POS_W'(mole);
                for (int p = 0; p < pause_len; p++) begin
                    step();
                    check_bit("pause_valid",  o_mole_valid, 1'b1);
                    check_bit("pause_hit_ok", o_hit_ok,     1'b0);
                    check_bit("pause_wrong",  o_hit_wrong,  1'b0);
                    check_bit("pause_miss",   o_miss,       1'b0);
                end
                i_enable    = 1'b1;
                i_hit_valid = 1'b0;
            end
            i_hit_valid = (e == hit_at) || (e == wrong_at);
            i_hit_pos   = (e == hit_at) ? POS_W'(mole) : wrong_pos;
            step();
            i_hit_valid = 1'b0;
            if (e == hit_at) begin
                check_bit("hit_ok",        o_hit_ok,            1'b1);
                check_bit("hit_no_miss",   o_miss,              1'b0);
                check_bit("hit_no_wrong",  o_hit_wrong,         1'b0);
                check_bit("hit_valid_low", o_mole_valid,        1'b0);
                check_val("hit_onehot",    int'(o_mole_onehot), 0);
                ok_hits++;
                done = 1'b1;
            end else if (e == L) begin
                check_bit("miss",          o_miss,              1'b1);
                check_bit("miss_no_hit",   o_hit_ok,            1'b0);
                check_bit("miss_wrong",    o_hit_wrong,         e == wrong_at);
                check_bit("miss_valid",    o_mole_valid,        1'b0);
                check_val("miss_onehot",   int'(o_mole_onehot), 0);
            end else begin
                check_bit("show_valid",    o_mole_valid,        1'b1);
                check_val("show_onehot",   int'(o_mole_onehot), 1 << mole);
                check_bit("show_miss",     o_miss,              1'b0);
                check_bit("show_hit_ok",   o_hit_ok,            1'b0);
                check_bit("show_wrong",    o_hit_wrong,         e == wrong_at);
            end
        end
    endtask

    // Blank gap with random ignored hits; the position stays on the last mole.
    task automatic do_gap();
        for (int g = 1; g <= GAP_CYCLES; g++) begin
            i_hit_valid = 1'($urandom_range(0, 1));
            i_hit_pos   = POS_W'($urandom_range(0, 7));
            step();
            check_quiet("gap");
            check_val("gap_pos", int'(o_mole_pos), last_pos);
        end
        i_hit_valid = 1'b0;
    endtask

    initial begin
        foreach (hole_count[i]) hole_count[i] = 0;

        // Reset: everything low, IDLE holds while disabled.
        #1;
        check_quiet("reset");
        check_val("reset_pos", int'(o_mole_pos), 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        check_quiet("reset_held");
        i_rst  = 1'b0;
        m_lfsr = LFSR_SEED;
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet("idle_hold");
        end
        i_enable = 1'b1;
        step();
        check_quiet("idle_to_pick");

        // First spawn, then a full unhit lifetime.
        do_pick();
        apply_stimulus(-1, 0, '0, 0, 0);
        do_gap();

        // Correct hit on the third SHOW cycle.
        do_pick();
        apply_stimulus(3, 0, '0, 0, 0);
        do_gap();

        // Out-of-range wrong hit, then a correct hit in the expiry cycle.
        do_pick();
        apply_stimulus(0, 2, 3'd7, 0, 0);
        do_gap();

        // Seven-cycle pause in the middle of SHOW.
        do_pick();
        apply_stimulus(-1, 0, '0, 4, 7);
        do_gap();

        // Zero lifetime behaves as one cycle.
        i_lifetime = 8'd0;
        do_pick();
        apply_stimulus(-1, 0, '0, 0, 0);
        i_lifetime = 8'd10;
        do_gap();

        // Asynchronous reset in the middle of SHOW.
        do_pick();
        step();
        check_bit("pre_reset_valid", o_mole_valid, 1'b1);
        #1;
        i_rst = 1'b1;
        #1;
        check_quiet("reset_mid");
        check_val("reset_mid_pos", int'(o_mole_pos), 0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst    = 1'b0;
        m_lfsr   = LFSR_SEED;
        last_pos = N_HOLES;
        prev_obs = -1;
        ok_hits  = 0;
        step();
        check_quiet("post_reset_idle");

        // 2000 random moles.
        foreach (hole_count[i]) hole_count[i] = 0;
        for (int s = 0; s < 2000; s++) begin
            int L;
            int hit_at;
            int wrong_at;
            int pause_at;
            int wp;
            do_pick();
            L        = exp_lifetime();
            hit_at   = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, L));
            wrong_at = int'($urandom_range(0, L));
            pause_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, L)) : 0;
            wp       = int'($urandom_range(0, 6));
            if (wp >= last_pos) wp++;
            apply_stimulus(hit_at, wrong_at, POS_W'(wp), pause_at, int'($urandom_range(1, 3)));
            do_gap();
        end
        for (int i = 0; i < N_HOLES; i++) begin
            check_bit($sformatf("hole_%0d_used_200", i), hole_count[i] >= 200, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
